// File: rtl/if_mem_port.sv
// Instruction-fetch channel: fetches four bytes from the shared 8-bit RAM and returns a
// little-endian 32-bit instruction with a one-cycle ok pulse. Supports abort and bus-loss stalls.
module if_mem_port #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ena_from_if,
  input  logic [ADDR_W-1:0] pc_from_if,
  input  logic              drop_flag_from_if,
  output logic              ok_flag_to_if,
  output logic [INST_W-1:0] inst_to_if,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [2:0]        issue_idx;
  logic [2:0]        recv_idx;
  logic              in_flight;
  logic [7:0]        byte0, byte1, byte2;
  logic              go;

  assign go     = rdy & bus_grant;
  assign mem_wr = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ok_flag_to_if <= 1'b0;
      inst_to_if    <= '0;
      mem_a         <= '0;
      bus_req       <= 1'b0;
      base          <= '0;
      issue_idx     <= '0;
      recv_idx      <= '0;
      in_flight     <= 1'b0;
      byte0         <= '0;
      byte1         <= '0;
      byte2         <= '0;
    end else begin
      ok_flag_to_if <= 1'b0;
      if (drop_flag_from_if) begin
        state     <= IDLE;
        bus_req   <= 1'b0;
        in_flight <= 1'b0;
        issue_idx <= '0;
        recv_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ena_from_if && rdy) begin
              base      <= pc_from_if;
              issue_idx <= '0;
              recv_idx  <= '0;
              in_flight <= 1'b0;
              bus_req   <= 1'b1;
              state     <= BUSY;
            end
          end
          BUSY: begin
            if (go) begin
              if (in_flight) begin
                case (recv_idx[1:0])
                  2'd0:    byte0 <= mem_din;
                  2'd1:    byte1 <= mem_din;
                  2'd2:    byte2 <= mem_din;
                  default: ;
                endcase
                recv_idx <= recv_idx + 3'd1;
              end
              if (in_flight && recv_idx == 3'd3) begin
                inst_to_if    <= {mem_din, byte2, byte1, byte0};
                ok_flag_to_if <= 1'b1;
                in_flight     <= 1'b0;
                bus_req       <= 1'b0;
                state         <= IDLE;
              end else if (issue_idx < 3'd4) begin
                mem_a     <= base + ADDR_W'(issue_idx);
                issue_idx <= issue_idx + 3'd1;
                in_flight <= 1'b1;
              end else begin
                in_flight <= 1'b0;
              end
            end else begin
              // Data arriving during a stall is unreliable; rewind to the oldest missing byte.
              in_flight <= 1'b0;
              issue_idx <= recv_idx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_mem_port.sv
// Randomized bench for if_mem_port: a byte-count fetch model with an expected-instruction
// queue, plus directed scenarios for stall, abort, async reset, wraparound and rdy-low requests.
module tb_if_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] pc = '0;
  logic        drop = 1'b0;
  logic        grant = 1'b0;
  logic        ok;
  logic [31:0] inst;
  logic        bus_req;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;

  logic [7:0]  ram [256];
  assign mem_din = ram[mem_a[7:0]];

  always #5 clk = ~clk;

  if_mem_port #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ena_from_if(ena), .pc_from_if(pc),
    .drop_flag_from_if(drop), .ok_flag_to_if(ok), .inst_to_if(inst),
    .bus_req(bus_req), .bus_grant(grant), .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  int checks = 0;
  int errors = 0;

  // Model: a fetch finishes after four byte receptions; a byte is received on a
  // granted cycle that follows another granted cycle of the same fetch.
  logic [31:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_prev_go = 1'b0;
  int          m_recv = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_inst = '0;
  logic        exp_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] assemble(input logic [31:0] p);
    logic [31:0] w;
    logic [31:0] a;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      a = p + 32'(i);
      w[8*i +: 8] = ram[a[7:0]];
    end
    return w;
  endfunction

  task automatic check_outputs();
    check("ok", {31'd0, ok}, {31'd0, exp_ok});
    check("bus_req", {31'd0, bus_req}, {31'd0, m_busy});
    check("mem_a", mem_a, m_addr);
    check("inst", inst, m_inst);
    check("mem_wr", {31'd0, mem_wr}, 32'd0);
  endtask

  task automatic step(input logic e, input logic [31:0] p, input logic d,
                      input logic r, input logic g);
    @(negedge clk);
    ena = e; pc = p; drop = d; rdy = r; grant = g;
    @(posedge clk);
    exp_ok = 1'b0;
    if (d) begin
      if (m_busy) void'(exp_q.pop_front());
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (r && g) begin
        if (m_prev_go) m_recv++;
        if (m_recv == 4) begin
          exp_ok = 1'b1;
          m_busy = 1'b0;
          m_inst = exp_q.pop_front();
        end else begin
          m_addr = m_base + 32'(m_recv);
        end
        m_prev_go = 1'b1;
      end else begin
        m_prev_go = 1'b0;
      end
    end else if (e && r) begin
      m_busy = 1'b1;
      m_prev_go = 1'b0;
      m_recv = 0;
      m_base = p;
      exp_q.push_back(assemble(p));
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_steps(input int n, input logic g);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1, g);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ena = 1'b0; drop = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_ok", {31'd0, ok}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    exp_q.delete();
    m_busy = 1'b0; m_prev_go = 1'b0; m_recv = 0;
    m_addr = '0; m_inst = '0; exp_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 255));
    ram[8'h10] = 8'h13; ram[8'h11] = 8'h05; ram[8'h12] = 8'hA0; ram[8'h13] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ok", {31'd0, ok}, 32'd0);
    check("reset_bus_req", {31'd0, bus_req}, 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal fetch: ok on the fifth edge after acceptance.
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
    idle_steps(5, 1'b1);
    check("t1_inst", inst, 32'h00A00513);

    // Grant lost for two cycles after byte 1 is issued.
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
    idle_steps(2, 1'b1);
    idle_steps(2, 1'b0);
    idle_steps(5, 1'b1);
    check("t2_inst", inst, 32'h00A00513);

    // Abort after two bytes received, then a clean fetch elsewhere.
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
    idle_steps(3, 1'b1);
    step(1'b1, 32'h30, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h20, 1'b0, 1'b1, 1'b1);
    idle_steps(5, 1'b1);
    check("t3_inst", inst, {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]});

    // Asynchronous reset in the middle of a fetch.
    step(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
    idle_steps(2, 1'b1);
    pulse_reset();
    idle_steps(2, 1'b1);

    // Address wraparound.
    step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
    idle_steps(5, 1'b1);
    check("t5_inst", inst, {ram[8'h01], ram[8'h00], ram[8'hFF], ram[8'hFE]});

    // Request while rdy is low is lost; retried with rdy high.
    step(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h50, 1'b0, 1'b1, 1'b1);
    idle_steps(5, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      step($urandom_range(0, 2) == 0, rp, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
